// File: rtl/distribuidor_pesado_pkg.sv
// Shared constants and helpers for the weighted distributor.
// Holds the default queue count, data width and weight range, and the
// per-queue weight width W derived from MAX_WEIGHT.
package distribuidor_pkg;

  localparam int QUEUE_QUANTITY = 4;
  localparam int DATA_BITS      = 8;
  localparam int MAX_WEIGHT     = 64;
  localparam int W              = $clog2(MAX_WEIGHT);
  localparam int STAT_BITS      = 16;

  // Index width for n queues; never collapses to zero bits.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + off) modulo qq, assuming base < qq and off < qq.
  function automatic int wrap_add(input int base, input int off, input int qq);
    int s;
    s = base + off;
    if (s >= qq) s = s - qq;
    return s;
  endfunction

endpackage

// File: rtl/distribuidor_pesado_if.sv
// Bus bundle for the weighted distributor: upstream valid/ready word
// stream, per-queue weights and full flags, and the FIFO write side.
// slave is the distributor's view, master is the driving environment.
interface distribuidor_pesado_if #(
  parameter int QUEUE_QUANTITY = distribuidor_pkg::QUEUE_QUANTITY,
  parameter int DATA_BITS      = distribuidor_pkg::DATA_BITS,
  parameter int MAX_WEIGHT     = distribuidor_pkg::MAX_WEIGHT
) ();
  import distribuidor_pkg::*;

  localparam int WEIGHT_W = $clog2(MAX_WEIGHT);
  localparam int SEL_W    = sel_bits(QUEUE_QUANTITY);

  logic                               enb;
  logic [QUEUE_QUANTITY*WEIGHT_W-1:0] pesos;
  logic                               in_valid;
  logic [DATA_BITS-1:0]               in_data;
  logic                               in_ready;
  logic [QUEUE_QUANTITY-1:0]          buf_full;
  logic [QUEUE_QUANTITY-1:0]          push;
  logic [DATA_BITS-1:0]               data_out;
  logic [SEL_W-1:0]                   dest_sel;

  modport slave (
    input  enb, pesos, in_valid, in_data, buf_full,
    output in_ready, push, data_out, dest_sel
  );

  modport master (
    output enb, pesos, in_valid, in_data, buf_full,
    input  in_ready, push, data_out, dest_sel
  );

endinterface

// File: rtl/distribuidor_pesado_buscador_circular.sv
// Rotating-priority search: starting at ptr and moving upward with
// wrap-around, returns the first eligible queue and whether any exists.
// With nothing eligible, dest echoes ptr and found is low.
module buscador_circular #(
  parameter  int QUEUE_QUANTITY = distribuidor_pkg::QUEUE_QUANTITY,
  localparam int SEL_W          = distribuidor_pkg::sel_bits(QUEUE_QUANTITY)
) (
  input  logic [SEL_W-1:0]          ptr,
  input  logic [QUEUE_QUANTITY-1:0] eligible,
  output logic [SEL_W-1:0]          dest,
  output logic                      found
);
  import distribuidor_pkg::*;

  // cand[k] is the queue visited k steps after ptr; hit[k] its eligibility.
  logic [SEL_W-1:0]          cand [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] hit;

  generate
    for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_cand
      assign cand[gi] = SEL_W'(wrap_add(int'(ptr), gi, QUEUE_QUANTITY));
      assign hit[gi]  = eligible[cand[gi]];
    end
  endgenerate

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    dest  = ptr;
    found = 1'b0;
    for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dest  = cand[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/distribuidor_pesado.sv
// Weighted round-robin distributor: each accepted word goes straight to
// one destination FIFO (zero latency); queue n receives up to weight[n]
// consecutive words per turn. Zero-weight or full queues are skipped.
// Optional per-queue push counters under DISTRIBUIDOR_PESADO_STATS_EN.
module distribuidor_pesado #(
  parameter  int QUEUE_QUANTITY = distribuidor_pkg::QUEUE_QUANTITY,
  parameter  int DATA_BITS      = distribuidor_pkg::DATA_BITS,
  parameter  int MAX_WEIGHT     = distribuidor_pkg::MAX_WEIGHT,
  localparam int SEL_W          = distribuidor_pkg::sel_bits(QUEUE_QUANTITY)
) (
  input  logic                 clk,
  input  logic                 rst,
  distribuidor_pesado_if.slave bus
`ifdef DISTRIBUIDOR_PESADO_STATS_EN
  ,
  output logic [QUEUE_QUANTITY*distribuidor_pkg::STAT_BITS-1:0] push_count
`endif
);
  import distribuidor_pkg::*;

  localparam int WEIGHT_W = $clog2(MAX_WEIGHT);

  logic [WEIGHT_W-1:0]       weight [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] eligible;

  logic [SEL_W-1:0]    ptr_reg, ptr_next;
  logic [WEIGHT_W-1:0] cnt_reg, cnt_next;

  logic [SEL_W-1:0]    dest_w;
  logic                found_w;
  logic [SEL_W-1:0]    ptr_after;
  logic [WEIGHT_W-1:0] rem_w;
  logic                ready_w;
  logic                accept_w;

  logic [QUEUE_QUANTITY-1:0] push_w;
  logic [DATA_BITS-1:0]      data_w;
  logic [SEL_W-1:0]          sel_w;

  // Unpack weights and decide which queues may take a word this cycle.
  generate
    for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_elig
      assign weight[gi]   = bus.pesos[gi*WEIGHT_W +: WEIGHT_W];
      assign eligible[gi] = (weight[gi] != '0) && !bus.buf_full[gi];
    end
  endgenerate

  buscador_circular #(
    .QUEUE_QUANTITY(QUEUE_QUANTITY)
  ) u_buscador (
    .ptr      (ptr_reg),
    .eligible (eligible),
    .dest     (dest_w),
    .found    (found_w)
  );

  // rst is active-low, so ready is only possible out of reset.
  assign ready_w  = rst && bus.enb && found_w;
  assign accept_w = ready_w && bus.in_valid;

  assign ptr_after = (dest_w == SEL_W'(QUEUE_QUANTITY - 1)) ? '0 : dest_w + SEL_W'(1);

  // Words left in the turn: continue the current count only when staying
  // on ptr; a skip starts a fresh turn at the skipped-to queue's weight.
  always_comb begin
    rem_w = weight[dest_w];
    if (dest_w == ptr_reg) begin
      rem_w = (cnt_reg == '0) ? weight[ptr_reg] : cnt_reg;
    end
  end

  // Turn bookkeeping; nothing moves (including a pending skip) without an accept.
  always_comb begin
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    if (accept_w) begin
      if (rem_w == WEIGHT_W'(1)) begin
        ptr_next = ptr_after;
        cnt_next = weight[ptr_after];
      end else begin
        ptr_next = dest_w;
        cnt_next = rem_w - WEIGHT_W'(1);
      end
    end
  end

  // Pointer and turn counter; reset restarts at queue 0 with a full turn.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg <= '0;
      cnt_reg <= weight[0];
    end else begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
    end
  end

  // FIFO write side: one-hot push and pass-through data on accept only.
  always_comb begin
    push_w = '0;
    data_w = '0;
    sel_w  = '0;
    if (rst) begin
      sel_w = found_w ? dest_w : ptr_reg;
      if (accept_w) begin
        push_w[dest_w] = 1'b1;
        data_w         = bus.in_data;
      end
    end
  end

  assign bus.in_ready = ready_w;
  assign bus.push     = push_w;
  assign bus.data_out = data_w;
  assign bus.dest_sel = sel_w;

`ifdef DISTRIBUIDOR_PESADO_STATS_EN
  logic [STAT_BITS-1:0] push_cnt_reg [QUEUE_QUANTITY];

  generate
    for (genvar gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_stats
      // Per-queue push counter, sticking at all-ones.
      always_ff @(posedge clk) begin
        if (!rst) begin
          push_cnt_reg[gi] <= '0;
        end else if (push_w[gi] && (push_cnt_reg[gi] != {STAT_BITS{1'b1}})) begin
          push_cnt_reg[gi] <= push_cnt_reg[gi] + STAT_BITS'(1);
        end
      end
      assign push_count[gi*STAT_BITS +: STAT_BITS] = push_cnt_reg[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_distribuidor_pesado.sv
// Bench for distribuidor_pesado: directed push sequences with hand-derived
// destinations are queued as expectations; a monitor checks each push.
module tb_distribuidor_pesado;

  localparam int QQ = 4;
  localparam int DB = 8;
  localparam int MW = 64;
  localparam int WW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  distribuidor_pesado_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB), .MAX_WEIGHT(MW)) bus ();

`ifdef DISTRIBUIDOR_PESADO_STATS_EN
  logic [QQ*16-1:0] push_count;
`endif

  distribuidor_pesado #(
    .QUEUE_QUANTITY(QQ),
    .DATA_BITS(DB),
    .MAX_WEIGHT(MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DISTRIBUIDOR_PESADO_STATS_EN
    ,
    .push_count (push_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         q;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] dseed = 8'h11;
  int         seq[$];

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    bus.pesos = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endtask

  task automatic send(input int q);
    exp_t e;
    e.q = q;
    e.d = dseed;
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = dseed;
    $display("send word %02h expecting queue %0d", dseed, q);
    dseed = dseed * 8'd5 + 8'd3;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask

  task automatic do_reset(input int w0, input int w1, input int w2, input int w3);
    set_w(w0, w1, w2, w3);
    bus.buf_full = '0;
    bus.enb      = 1'b1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Monitor: every observed push must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.push != '0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_push: got push %b data %02h, required no push", bus.push, bus.data_out);
        end else begin
          e = exp_q.pop_front();
          chk("push_onehot", int'(bus.push), 1 << e.q);
          chk("data_out", int'(bus.data_out), int'(e.d));
        end
      end
    end
  end

  initial begin
    bus.enb      = 1'b1;
    bus.pesos    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.buf_full = '0;
    rst          = 1'b0;
    set_w(1, 2, 3, 4);
    tick();

    // Reset state with a valid word offered: nothing may leave.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_data_out", int'(bus.data_out), 0);
    chk("reset_dest_sel", int'(bus.dest_sel), 0);
    chk("reset_push", int'(bus.push), 0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.in_ready), 1);
    chk("dest_after_reset", int'(bus.dest_sel), 0);
    tick();

    // Weights 1,2,3,4: two full rounds.
    seq = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    send_seq();
    send_seq();

    // Disabled: no ready, state held (next is q0).
    bus.enb      = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready_enb0", int'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.enb      = 1'b1;
    send(0);
    send(1);

    // All full mid-turn on q1: blocked, pointer kept for after release.
    bus.buf_full = 4'hF;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ready_all_full", int'(bus.in_ready), 0);
      chk("dest_all_full", int'(bus.dest_sel), 1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.buf_full = '0;
    seq = '{1, 2, 2, 2, 3};
    send_seq();

    // Weights 2 each with q1 full throughout.
    do_reset(2, 2, 2, 2);
    bus.buf_full = 4'b0010;
    seq = '{0, 0, 2, 2, 3, 3, 0, 0, 2};
    send_seq();
    bus.buf_full = '0;

    // Weights 0,3,0,1: zero-weight queues skipped from the start.
    do_reset(0, 3, 0, 1);
    @(negedge clk);
    chk("dest_skip_zero", int'(bus.dest_sel), 1);
    chk("ready_skip_zero", int'(bus.in_ready), 1);
    tick();
    seq = '{1, 1, 1, 3, 1, 1, 1, 3};
    send_seq();

    // Reset after one of three q2 words: fresh turn at q0.
    do_reset(1, 2, 3, 4);
    seq = '{0, 1, 1, 2};
    send_seq();
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    @(negedge clk);
    chk("midturn_reset_push", int'(bus.push), 0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    send(0);
    send(1);

    // Destination full in the same cycle: skip to q1 with a fresh turn.
    do_reset(1, 2, 3, 4);
    bus.buf_full = 4'b0001;
    @(negedge clk);
    chk("dest_full_skip", int'(bus.dest_sel), 1);
    tick();
    send(1);
    bus.buf_full = '0;
    send(1);
    send(2);

    // Weight change mid-turn: current q1 turn not stretched, new weight next round.
    do_reset(1, 2, 3, 4);
    send(0);
    send(1);
    set_w(1, 5, 3, 4);
    seq = '{1, 2, 2, 2, 3, 3, 3, 3, 0, 1, 1, 1, 1, 1, 2};
    send_seq();

`ifdef DISTRIBUIDOR_PESADO_STATS_EN
    // Counter saturation on lane 0.
    do_reset(1, 0, 0, 0);
    repeat (70000) send(0);
    @(negedge clk);
    chk("push_count_lane0", int'(push_count[15:0]), 32'h0000FFFF);
    chk("push_count_lane1", int'(push_count[31:16]), 0);
    chk("push_count_lane2", int'(push_count[47:32]), 0);
    chk("push_count_lane3", int'(push_count[63:48]), 0);
    tick();
`endif

    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/distribuidor_pesado.md
DISTRIBUIDOR_PESADO -- requirements
Module: distribuidor_pesado

Interface
REQ-001 Parameter QUEUE_QUANTITY, default 4, SHALL set the number of destination FIFOs.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the data word width.
REQ-003 Parameter MAX_WEIGHT, default 64, SHALL set the weight range; W = $clog2(MAX_WEIGHT) bits per weight, so weights span 0..MAX_WEIGHT-1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 enb  input  1  SHALL be the block enable; when 0, in_ready=0 and no state changes.
REQ-007 pesos  input  QUEUE_QUANTITY*W  SHALL carry the weight of queue n in bits [(n+1)*W-1 : n*W].
REQ-008 in_valid  input  1  SHALL mark in_data as valid.
REQ-009 in_data  input  DATA_BITS  SHALL be the incoming word.
REQ-010 in_ready  output  1  SHALL indicate the block accepts in_data this cycle.
REQ-011 buf_full  input  QUEUE_QUANTITY  SHALL carry the per-FIFO full flags.
REQ-012 push  output  QUEUE_QUANTITY  SHALL be the one-hot FIFO write enables.
REQ-013 data_out  output  DATA_BITS  SHALL be the word written to the selected FIFO.
REQ-014 dest_sel  output  $clog2(QUEUE_QUANTITY)  SHALL be the current destination index.

Function
REQ-015 State: pointer ptr plus turn counter cnt (W bits), both registered.
REQ-016 Eligibility: queue q is eligible iff weight[q]!=0 and buf_full[q]==0.
REQ-017 Destination (combinational): dest=ptr if ptr is eligible, else the first eligible queue searching ptr+1, ptr+2, ... modulo QUEUE_QUANTITY.
REQ-018 Remaining words: rem = (cnt==0 ? weight[ptr] : cnt) when dest==ptr, else weight[dest].
REQ-019 in_ready SHALL be 1 iff rst==1, enb==1 and at least one queue is eligible.
REQ-020 Accept = in_valid & in_ready; on accept, push SHALL have bit dest set and data_out=in_data in the same cycle, giving zero latency; otherwise push=0.
REQ-021 On accept with rem==1: ptr <= (dest+1) mod QUEUE_QUANTITY and cnt <= weight of that queue.
REQ-022 On accept with rem>1: ptr <= dest and cnt <= rem-1.
REQ-023 No accept: ptr and cnt hold, and a skip toward dest is not committed.
REQ-024 All queues ineligible: in_ready=0 and push=0; dest_sel=ptr.
REQ-025 Wrap-around: index QUEUE_QUANTITY-1 advances to 0.
REQ-026 A weight change takes effect at the next cnt load; an in-progress turn is not shortened.
REQ-027 When dest's FIFO asserts buf_full in the same cycle, that queue is not selected.

Reset
REQ-028 With rst==0 at a clock edge: ptr<=0, cnt<=weight[0].
REQ-029 While rst==0: push=0, in_ready=0, data_out=0, dest_sel=0.
REQ-030 Reset asserted mid-turn SHALL discard the turn with no partial push.

Configuration
REQ-031 With DISTRIBUIDOR_PESADO_STATS_EN defined, output push_count[QUEUE_QUANTITY*16] SHALL count pushes per queue.
REQ-032 Each push_count lane saturates at 16'hFFFF and resets to 0.
REQ-033 Without DISTRIBUIDOR_PESADO_STATS_EN, the push_count port and its counters SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Shared package distribuidor_pkg SHALL hold the defaults QUEUE_QUANTITY, DATA_BITS, MAX_WEIGHT and the per-queue weight-width constant W.
REQ-035 Sub-module buscador_circular SHALL implement the rotating-priority search of REQ-017.
REQ-036 buscador_circular inputs: ptr and eligible[QUEUE_QUANTITY]. Outputs: dest and found.

Verification
REQ-037 Weights {1,2,3,4} (q0..q3), all not full, in_valid constant -> repeating push sequence q0,q1,q1,q2,q2,q2,q3,q3,q3,q3.
REQ-038 Weights {2,2,2,2}, buf_full[1]=1 throughout -> sequence q0,q0,q2,q2,q3,q3,q0; q1 never pushed.
REQ-039 All buf_full=1 -> in_ready=0 and push=0 every cycle; ptr unchanged after release.
REQ-040 Weights {0,3,0,1} after reset -> first push q1 with data_out=in_data same cycle; sequence q1,q1,q1,q3.
REQ-041 rst=0 for one cycle after 1 of 3 q2 words -> next push goes to q0 with a fresh turn.
REQ-042 STATS_EN build, 70000 pushes to q0 only -> push_count lane 0 = 16'hFFFF, other lanes 0.
